// File: rtl/oled_pkg.sv
// Shared types and SSD1306 command constants for the OLED text sequencer.
package oled_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CMD, DATA} state_e;

    localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
    localparam logic [7:0] CMD_COL_LO    = 8'h00;
    localparam logic [7:0] CMD_COL_HI    = 8'h10;
    localparam int         GLYPH_BYTES   = 8;

    // Line-start command bytes: set page, then column 0 (low nibble, high nibble).
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [2:0] page);
        case (idx)
            2'd0:    return CMD_PAGE_BASE | {5'd0, page};
            2'd1:    return CMD_COL_LO;
            default: return CMD_COL_HI;
        endcase
    endfunction

endpackage

// File: rtl/oled_text_sequencer_if.sv
// Character-in / byte-out handshake bundle between text source, sequencer and SPI transmitter.
interface oled_text_sequencer_if;
    logic       char_valid;
    logic       char_ready;
    logic [6:0] char_code;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_dc;

    modport master (
        output char_valid, char_code, clear, out_ready,
        input  char_ready, out_valid, out_byte, out_dc
    );

    modport slave (
        input  char_valid, char_code, clear, out_ready,
        output char_ready, out_valid, out_byte, out_dc
    );
endinterface

// File: rtl/oled_cursor.sv
// Text cursor: column counter that wraps into a page counter; home has priority over advance.
module oled_cursor #(
    parameter int  COLS_PER_PAGE = 16,
    parameter int  NUM_PAGES     = 4,
    localparam int COL_W         = $clog2(COLS_PER_PAGE),
    localparam int PAGE_W        = $clog2(NUM_PAGES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic              home,
    output logic [PAGE_W-1:0] page,
    output logic [COL_W-1:0]  col
);

    logic [PAGE_W-1:0] page_q, page_d;
    logic [COL_W-1:0]  col_q, col_d;

    always_comb begin
        page_d = page_q;
        col_d  = col_q;
        if (home) begin
            page_d = '0;
            col_d  = '0;
        end else if (advance) begin
            if (col_q == COL_W'(COLS_PER_PAGE - 1)) begin
                col_d  = '0;
                // No scrolling: the last page silently wraps back to the first.
                page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            page_q <= '0;
            col_q  <= '0;
        end else begin
            page_q <= page_d;
            col_q  <= col_d;
        end
    end

    assign page = page_q;
    assign col  = col_q;

endmodule

// File: rtl/oled_text_sequencer.sv
// Turns 7-bit character codes into SSD1306 command/data bytes using an external glyph ROM.
module oled_text_sequencer
    import oled_pkg::*;
#(
    parameter int  COLS_PER_PAGE = 16,
    parameter int  NUM_PAGES     = 4,
    localparam int COL_W         = $clog2(COLS_PER_PAGE),
    localparam int PAGE_W        = $clog2(NUM_PAGES)
) (
    input  logic                        clock,
    input  logic                        reset,
    oled_text_sequencer_if.slave        bus,
    output logic [6:0]                  rom_addr,
    input  logic [63:0]                 rom_data,
    output logic                        busy,
    output logic [PAGE_W-1:0]           page,
    output logic [COL_W-1:0]            col
);

    state_e      state_q, state_d;
    logic [6:0]  code_q, code_d;
    logic [63:0] shift_q, shift_d;
    logic [1:0]  cmd_idx_q, cmd_idx_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic        clear_pend_q, clear_pend_d;
    logic        out_valid_q, out_valid_d;
    logic        out_dc_q, out_dc_d;
    logic [7:0]  out_byte_q, out_byte_d;
    logic        char_ready_int;
    logic        advance, home;

    // A clear pulse in IDLE steals the cycle so the homed cursor applies to the next character.
    assign char_ready_int = (state_q == IDLE) && !clear_pend_q && !bus.clear;

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        shift_d      = shift_q;
        cmd_idx_d    = cmd_idx_q;
        byte_idx_d   = byte_idx_q;
        clear_pend_d = clear_pend_q | ((state_q != IDLE) && bus.clear);
        advance      = 1'b0;
        home         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    home = 1'b1;
                end else if (char_ready_int && bus.char_valid) begin
                    code_d  = bus.char_code;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = rom_data;
                if (col == '0) begin
                    state_d   = CMD;
                    cmd_idx_d = 2'd0;
                end else begin
                    state_d    = DATA;
                    byte_idx_d = 3'd0;
                end
            end
            CMD: begin
                if (bus.out_ready) begin
                    cmd_idx_d = cmd_idx_q + 2'd1;
                    if (cmd_idx_q == 2'd2) begin
                        state_d    = DATA;
                        byte_idx_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (bus.out_ready) begin
                    shift_d    = shift_q << 8;
                    byte_idx_d = byte_idx_q + 3'd1;
                    if (byte_idx_q == 3'(GLYPH_BYTES - 1)) begin
                        state_d = IDLE;
                        // A clear seen during the glyph replaces the normal cursor advance.
                        if (clear_pend_q || bus.clear) begin
                            home         = 1'b1;
                            clear_pend_d = 1'b0;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state values so they never glitch.
        out_valid_d = (state_d == CMD) || (state_d == DATA);
        out_dc_d    = (state_d == DATA);
        out_byte_d  = 8'h00;
        if (state_d == CMD)
            out_byte_d = cmd_byte(cmd_idx_d, 3'(page));
        else if (state_d == DATA)
            out_byte_d = shift_d[63:56];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            code_q       <= '0;
            shift_q      <= '0;
            cmd_idx_q    <= '0;
            byte_idx_q   <= '0;
            clear_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_dc_q     <= 1'b0;
            out_byte_q   <= '0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            shift_q      <= shift_d;
            cmd_idx_q    <= cmd_idx_d;
            byte_idx_q   <= byte_idx_d;
            clear_pend_q <= clear_pend_d;
            out_valid_q  <= out_valid_d;
            out_dc_q     <= out_dc_d;
            out_byte_q   <= out_byte_d;
        end
    end

    oled_cursor #(
        .COLS_PER_PAGE (COLS_PER_PAGE),
        .NUM_PAGES     (NUM_PAGES)
    ) u_cursor (
        .clock   (clock),
        .reset   (reset),
        .advance (advance),
        .home    (home),
        .page    (page),
        .col     (col)
    );

    assign rom_addr       = code_q;
    assign bus.char_ready = char_ready_int && !reset;
    assign bus.out_valid  = out_valid_q && !reset;
    assign bus.out_dc     = out_dc_q && !reset;
    assign bus.out_byte   = reset ? 8'h00 : out_byte_q;
    assign busy           = (state_q != IDLE) && !reset;

endmodule

// File: tb/tb_oled_text_sequencer.sv
// Scoreboarded bench for oled_text_sequencer: glyph table, back-pressure, wrap, clear and reset cases.
module tb_oled_text_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  rom_addr;
    logic [63:0] rom_data;
    logic        busy;
    logic [1:0]  page;
    logic [3:0]  col;

    oled_text_sequencer_if bus();

    oled_text_sequencer dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .page     (page),
        .col      (col)
    );

    always #5 clock = ~clock;

    localparam logic [63:0] GLYPH_A   = 64'h407C4A094A7C4000;
    localparam logic [63:0] GLYPH_B   = 64'h417F494949493600;
    localparam logic [63:0] GLYPH_C   = 64'h1C22414141412200;
    localparam logic [63:0] GLYPH_DEL = 64'hAA55AA55AA55AA55;

    function automatic logic [63:0] rom_fn(input logic [6:0] a);
        case (a)
            7'h41:   return GLYPH_A;
            7'h42:   return GLYPH_B;
            7'h43:   return GLYPH_C;
            7'h7F:   return GLYPH_DEL;
            default: return (a < 7'd32) ? 64'd0 : ({8{1'b0, a}} ^ 64'h0102040810204080);
        endcase
    endfunction

    always_comb rom_data = rom_fn(rom_addr);

    typedef struct {
        logic [6:0]  code;
        logic [63:0] glyph;
        logic [3:0]  exp_col;
    } vec_t;

    int         checks = 0;
    int         passed = 0;
    logic [8:0] sbq[$];
    int         m_page = 0;
    int         m_col  = 0;
    int         n_xfer = 0;
    bit         s_ov, s_dc, s_cr, s_busy;
    logic [7:0] s_byte;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: sample at the falling edge, score any byte transfer, return just after the rising edge.
    task automatic tick(output bit acc);
        logic [8:0] e;
        @(negedge clock);
        acc    = bus.char_valid && bus.char_ready;
        s_ov   = bus.out_valid;
        s_dc   = bus.out_dc;
        s_byte = bus.out_byte;
        s_cr   = bus.char_ready;
        s_busy = busy;
        if (bus.out_valid && bus.out_ready) begin
            n_xfer++;
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_byte: got dc=%0d byte=%02h, expected none", bus.out_dc, bus.out_byte);
            end else begin
                e = sbq.pop_front();
                check("out_stream", 64'({bus.out_dc, bus.out_byte}), 64'(e));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push_char(input logic [63:0] glyph);
        if (m_col == 0) begin
            sbq.push_back({1'b0, 8'hB0 | 8'(m_page)});
            sbq.push_back(9'h000);
            sbq.push_back(9'h010);
        end
        for (int b = 0; b < 8; b++) sbq.push_back({1'b1, glyph[63-8*b -: 8]});
        if (m_col == 15) begin
            m_col  = 0;
            m_page = (m_page + 1) % 4;
        end else begin
            m_col++;
        end
    endtask

    task automatic send_char(input logic [6:0] code, input logic [63:0] glyph, output int waited);
        bit acc = 1'b0;
        waited = 0;
        bus.char_valid = 1'b1;
        bus.char_code  = code;
        while (!acc && waited < 100) begin
            tick(acc);
            waited++;
        end
        bus.char_valid = 1'b0;
        check("char_accepted", 64'(acc), 64'd1);
        if (acc) push_char(glyph);
    endtask

    task automatic wait_idle();
        bit a;
        int n = 0;
        while ((busy || sbq.size() != 0) && n < 300) begin
            tick(a);
            n++;
        end
        check("idle_reached", 64'(n < 300), 64'd1);
    endtask

    task automatic wait_xfers(input int target);
        bit a;
        int n = 0;
        while (n_xfer < target && n < 100) begin
            tick(a);
            n++;
        end
        check("xfer_reached", 64'(n_xfer >= target), 64'd1);
    endtask

    initial begin
        vec_t tbl[4];
        int   w, w2, base;
        bit   a;

        tbl[0] = '{code: 7'h7F, glyph: GLYPH_DEL, exp_col: 4'd4};
        tbl[1] = '{code: 7'h05, glyph: 64'd0,     exp_col: 4'd5};
        tbl[2] = '{code: 7'h41, glyph: GLYPH_A,   exp_col: 4'd6};
        tbl[3] = '{code: 7'h43, glyph: GLYPH_C,   exp_col: 4'd7};

        bus.char_valid = 1'b0;
        bus.char_code  = '0;
        bus.clear      = 1'b0;
        bus.out_ready  = 1'b1;
        reset          = 1'b1;

        // Reset state.
        tick(a);
        tick(a);
        check("rst_char_ready", 64'(s_cr), 64'd0);
        check("rst_out_valid", 64'(s_ov), 64'd0);
        check("rst_busy", 64'(s_busy), 64'd0);
        check("rst_out_byte", 64'(s_byte), 64'd0);
        check("rst_out_dc", 64'(s_dc), 64'd0);
        reset = 1'b0;
        tick(a);
        check("idle_char_ready", 64'(s_cr), 64'd1);
        check("idle_cursor", 64'({page, col}), 64'd0);

        // 'A' at line start, with first-byte latency.
        send_char(7'h41, GLYPH_A, w);
        tick(a);
        check("lat_load_no_valid", 64'(s_ov), 64'd0);
        tick(a);
        check("lat_first_valid", 64'(s_ov), 64'd1);
        wait_idle();
        check("after_A_cursor", 64'({page, col}), 64'({2'd0, 4'd1}));

        // 'B' mid-line: no commands.
        send_char(7'h42, GLYPH_B, w);
        wait_idle();
        check("after_B_col", 64'(col), 64'd2);

        // 'C' with 5 stalled cycles after three bytes.
        base = n_xfer;
        send_char(7'h43, GLYPH_C, w);
        wait_xfers(base + 3);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(a);
            check("bp_valid", 64'(s_ov), 64'd1);
            check("bp_hold_byte", 64'({s_dc, s_byte}), 64'h141);
        end
        check("bp_no_xfer", 64'(n_xfer), 64'(base + 3));
        bus.out_ready = 1'b1;
        wait_idle();
        check("bp_total_bytes", 64'(n_xfer), 64'(base + 8));

        // Table of glyphs including code 127 and a control code.
        for (int i = 0; i < 4; i++) begin
            send_char(tbl[i].code, tbl[i].glyph, w);
            wait_idle();
            check("tbl_col", 64'(col), 64'(tbl[i].exp_col));
        end

        // Mid-line throughput.
        send_char(7'h42, GLYPH_B, w);
        send_char(7'h43, GLYPH_C, w2);
        check("thru_midline", 64'(w2), 64'd10);
        wait_idle();

        // Reset during DATA byte 2.
        base = n_xfer;
        send_char(7'h41, GLYPH_A, w);
        wait_xfers(base + 2);
        sbq.delete();
        reset = 1'b1;
        tick(a);
        reset  = 1'b0;
        m_page = 0;
        m_col  = 0;
        tick(a);
        check("mid_rst_out_valid", 64'(s_ov), 64'd0);
        check("mid_rst_char_ready", 64'(s_cr), 64'd1);
        check("mid_rst_cursor", 64'({page, col}), 64'd0);
        send_char(7'h41, GLYPH_A, w);
        wait_idle();
        check("post_rst_col", 64'(col), 64'd1);

        // Line-start throughput, then page wrap across all 64 cells.
        reset = 1'b1;
        tick(a);
        reset  = 1'b0;
        m_page = 0;
        m_col  = 0;
        for (int i = 0; i < 65; i++) begin
            logic [6:0] c;
            c = 7'(32 + (i % 90));
            send_char(c, rom_fn(c), w);
            if (i == 1) check("thru_line_start", 64'(w), 64'd13);
            if (i == 16) begin
                wait_idle();
                check("wrap_page1", 64'({page, col}), 64'({2'd1, 4'd1}));
            end
        end
        wait_idle();
        check("wrap_full", 64'({page, col}), 64'({2'd0, 4'd1}));

        // clear during DATA byte 4 of the 5th character on the line.
        for (int i = 0; i < 3; i++) begin
            send_char(7'h42, GLYPH_B, w);
            wait_idle();
        end
        base = n_xfer;
        send_char(7'h43, GLYPH_C, w);
        wait_xfers(base + 4);
        bus.clear = 1'b1;
        tick(a);
        check("clr_busy_ready", 64'(s_cr), 64'd0);
        bus.clear = 1'b0;
        tick(a);
        check("clr_pend_ready", 64'(s_cr), 64'd0);
        wait_idle();
        check("clr_glyph_done", 64'(n_xfer), 64'(base + 8));
        check("clr_cursor", 64'({page, col}), 64'd0);
        m_page = 0;
        m_col  = 0;
        send_char(7'h42, GLYPH_B, w);
        wait_idle();
        check("clr_next_col", 64'(col), 64'd1);

        // clear in IDLE blocks a simultaneously offered character.
        bus.char_valid = 1'b1;
        bus.char_code  = 7'h41;
        bus.clear      = 1'b1;
        tick(a);
        check("idle_clr_not_accepted", 64'(a), 64'd0);
        bus.clear      = 1'b0;
        bus.char_valid = 1'b0;
        tick(a);
        check("idle_clr_cursor", 64'({page, col}), 64'd0);
        check("idle_clr_busy", 64'(busy), 64'd0);

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/oled_text_sequencer.md
Name: oled_text_sequencer

Overview:
Converts a stream of 7-bit character codes into the byte stream for a 128x32 SSD1306-class OLED. It tracks a text cursor of 16 columns by 4 pages. For each character it looks up the 8-column glyph in the external char_rom (combinational, 7-bit addr, 64-bit data) and emits page/column address commands at each line start, then 8 glyph data bytes. It sits between the text source and the SPI byte transmitter, with a valid/ready handshake on both sides.

Parameters:
COLS_PER_PAGE, 16, characters per display page (line); cursor column wraps here
NUM_PAGES, 4, display pages; cursor page wraps here
GLYPH_BYTES, 8, bytes per glyph; fixed by the 64-bit ROM word

Ports:
clock  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high reset
char_valid  input  1  char_code valid
char_ready  output  1  sequencer can accept a character this cycle
char_code  input  7  character code (0..127), used directly as ROM address
clear  input  1  one-cycle pulse: home cursor to page 0, column 0
rom_addr  output  7  address to char_rom
rom_data  input  64  glyph from char_rom; column 0 = [63:56], column 7 = [7:0]
out_valid  output  1  out_byte/out_dc valid
out_ready  input  1  transmitter accepts byte
out_byte  output  8  command or data byte
out_dc  output  1  0 = command byte, 1 = display data byte
busy  output  1  high in any state other than IDLE
page  output  2  current cursor page
col  output  4  current cursor column

Behaviour:
- Transactions:
  - Character transfer: char_valid & char_ready on a rising edge.
  - Output transfer: out_valid & out_ready on a rising edge.
- Reset (any cycle, including mid-glyph):
  - state = IDLE; page = 0; col = 0; code_q = 0; shift register = 0; clear_pend = 0.
  - Any partial glyph is abandoned.
  - Output values under reset: char_ready = 0, out_valid = 0, out_byte = 0, out_dc = 0, busy = 0.
- After reset releases: char_ready = 1 in IDLE.
- char_ready = (state == IDLE) & ~clear_pend. It is combinational from state only, never from char_valid.
- rom_addr = code_q (registered), never driven combinationally from char_code.
- States:
  - IDLE: on a character transfer, code_q <= char_code, go to LOAD.
  - LOAD: one cycle.
    - shift <= rom_data.
    - If col == 0: go to CMD with cmd_idx = 0. Otherwise go to DATA with byte_idx = 0.
  - CMD: out_valid = 1, out_dc = 0. out_byte per cmd_idx:
    - 0 → 8'hB0 | page
    - 1 → 8'h00 (column low nibble 0)
    - 2 → 8'h10 (column high nibble 0)
    - Each transfer increments cmd_idx. After the transfer at idx 2, go to DATA with byte_idx = 0.
  - DATA: out_valid = 1, out_dc = 1, out_byte = shift[63:56].
    - Each transfer: shift <<= 8, byte_idx++.
    - On the transfer at byte_idx == 7: advance the cursor, go to IDLE.
- Cursor advance:
  - If col == COLS_PER_PAGE-1: col = 0, page = (page + 1) mod NUM_PAGES. Otherwise col++.
  - Page wrap 3 → 0 is silent; there is no scroll.
- Latency: character accepted at edge T → out_valid high from cycle T+2 (LOAD occupies T+1).
- Back-pressure:
  - While out_valid & ~out_ready, out_byte and out_dc hold stable and no state advances.
  - out_valid never drops without a transfer, except on reset.
- Throughput with out_ready tied high:
  - 10 cycles per character mid-line (1 IDLE, 1 LOAD, 8 DATA).
  - 13 cycles at col 0 (adds 3 CMD).
- clear:
  - In IDLE: page = 0, col = 0 on the next edge. A character offered in the same cycle is NOT accepted (char_ready is forced 0 that cycle by the clear).
  - While busy: clear_pend is set. The current glyph completes normally (cursor advance suppressed), then page = col = 0 and clear_pend clears on entering IDLE.
  - clear and reset together: reset wins.
- Codes 0..31 are emitted like any other code (the ROM returns zeros → blank cell). Code 127 emits AA,55,AA,55,AA,55,AA,55.

Decomposition:
- oled_pkg holds:
  - state enum {IDLE, LOAD, CMD, DATA}
  - CMD_PAGE_BASE = 8'hB0, CMD_COL_LO = 8'h00, CMD_COL_HI = 8'h10
  - GLYPH_BYTES = 8
- Sub-module: oled_cursor (col/page counter with advance, clear, and wrap parameters). The FSM and shift register stay in the top module.
- char_rom is instantiated by the parent and is not inside this block.

Test Plan:
- Reset, then 'A' (0x41), out_ready = 1 → dc=0: B0,00,10; then dc=1: 40,7C,4A,09,4A,7C,40,00. out_valid first high at T+2; cursor afterwards page 0, col 1.
- Next char 'B' (0x42) → no command bytes; dc=1: 41,7F,49,49,49,49,36,00; col = 2.
- Back-pressure: out_ready low for 5 cycles at byte 3 of 'C' (0x43) → out_byte holds 41 stable, no duplicate or missing bytes; full stream 1C,22,41,41,41,41,22,00.
- Wrap: 16 chars on page 0, then 17th char → first bytes B1,00,10. After 64 chars the 65th emits B0; page = 0, col = 1.
- clear at DATA byte 4 of the 5th char → glyph completes all 8 bytes; char_ready stays low until IDLE. Next char emits B0,00,10 with col = 0 before it.
- Reset asserted at DATA byte 2 → next cycle out_valid = 0, char_ready = 1, page = col = 0. Next char restarts cleanly with B0,00,10.
